// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble-serial adder and its 4-bit slice.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_cin.sv
// Combinational 4-bit + 4-bit + carry-in adder; the single time-shared slice.
module nibble_add_cin
  import nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract built by sequencing one 4-bit slice over the operands,
// least-significant nibble first, one nibble per clock.
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE), with
  // op/a/b sampled on that edge; done pulses for one cycle NIB edges later,
  // and sum/cout/ovf are valid in that cycle. start while busy=1 is dropped.

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_c;

  nibble_add_cin u_slice (
    .a    (opa[idx*NIBBLE_W +: NIBBLE_W]),
    .b    (opb[idx*NIBBLE_W +: NIBBLE_W]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry <= slice_c;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            cout  <= slice_c;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            opa   <= a;
            opb   <= (op == OP_SUB) ? ~b : b;
            carry <= (op == OP_SUB);
            idx   <= '0;
            sum   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign ovf  = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (WIDTH=16) with a queue scoreboard.
module tb_nibble_serial_adder;

  localparam int W  = 16;
  localparam int EW = W + 2 + 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int          checks;
  int          errors;
  logic [31:0] cyc;
  logic [EW-1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("sum",       {16'd0, sum}, {16'd0, e[EW-1 -: W]});
        chk("cout",      {31'd0, cout}, {31'd0, e[33]});
        chk("ovf",       {31'd0, ovf},  {31'd0, e[32]});
        chk("done_cycle", cyc, e[31:0]);
      end
    end
  end

  // driver: call at a negedge; returns at the negedge after acceptance
  task automatic issue(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    exp_q.push_back({es, ec, eo, cyc + 32'd5});
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 1'($urandom_range(0, 1));
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    chk("rst_sum",  {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic arithmetic vectors
    issue(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0); drain();
    chk("sum_held_idle", {16'd0, sum}, 32'h2233);
    chk("done_low_idle", {31'd0, done}, 32'd0);
    issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0); drain();
    issue(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1); drain();
    issue(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0); drain();
    issue(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1); drain();

    // start while busy is ignored
    issue(1'b0, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_mid_run", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // back-to-back: start held in the DONE cycle
    issue(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    wait_done();
    issue(1'b1, 16'h1000, 16'h1000, 16'h0000, 1'b1, 1'b0);
    drain();

    // reset in the middle of RUN
    issue(1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_sum",  {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    chk("midrst_ovf",  {31'd0, ovf},  32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1'b0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
